// File: rtl/lat_test_ctrl_pkg.sv
// Shared definitions for the latency-test sequencer: box position codes
// driven on lt_mode and the sequencer state encoding.
package lat_test_ctrl_pkg;

    localparam logic [1:0] LT_POS_TOPLEFT     = 2'd0;
    localparam logic [1:0] LT_POS_CENTER      = 2'd1;
    localparam logic [1:0] LT_POS_BOTTOMRIGHT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_MEASURE  = 2'd2,
        ST_COOLDOWN = 2'd3
    } lt_state_t;

endpackage

// File: rtl/lat_sensor_sync.sv
// Multi-flop synchronizer bringing the asynchronous light sensor into clk27.
module lat_sensor_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic sensor_in,
    output logic sens_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            // Single-stage capture of the sensor level.
            always_ff @(posedge clk27 or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= sensor_in;
            end
        end else begin : g_chain
            // Shift the sensor level through the synchronizer chain.
            always_ff @(posedge clk27 or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_in};
            end
        end
    endgenerate

    assign sens_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/lat_test_ctrl.sv
// Latency-test sequencer for the 720x480 pattern generator: waits for a frame
// boundary, lights the test box, counts clk27 cycles until the sensor sees it,
// posts the count and then keeps the box dark for a few frames.
// Build option: LAT_TEST_CTRL_AVG_EN runs 8 measurements per start and posts
// their average.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start, lt_active low
// ARM      | waiting for a VSYNC falling edge with the sensor dark
// MEASURE  | box lit, counting cycles until sensor or timeout
// COOLDOWN | box dark, waiting COOLDOWN_FRAMES frames and a dark sensor
module lat_test_ctrl
    import lat_test_ctrl_pkg::*;
#(
    parameter int              CNT_W           = 24,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC    = 24'd2700000,
    parameter logic [3:0]      COOLDOWN_FRAMES = 4'd3,
    parameter int              SYNC_STAGES     = 2
) (
    input  logic             clk27,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode_sel,
    input  logic             vsync_in,
    input  logic             sensor_in,
    output logic             lt_active,
    output logic [1:0]       lt_mode,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] latency_cyc
);

    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_CYC - 1'b1;

    lt_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] latency_nxt;
    logic [3:0]       fcnt, fcnt_nxt;
    logic             lt_active_nxt, done_nxt, timeout_nxt;
    logic [1:0]       lt_mode_nxt;
    logic             sens_s, vs_d, vs_fall;

`ifdef LAT_TEST_CTRL_AVG_EN
    localparam logic [2:0] AVG_LAST_RUN = 3'd7;
    logic [CNT_W+2:0] acc, acc_nxt, acc_sum;
    logic [2:0]       run, run_nxt;
    logic             last, last_nxt;
`endif

    lat_sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk27     (clk27),
        .reset_n   (reset_n),
        .sensor_in (sensor_in),
        .sens_s    (sens_s)
    );

    // Remember last VSYNC level to find the start of each frame (active-low pulse).
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) vs_d <= 1'b0;
        else          vs_d <= vsync_in;
    end

    assign vs_fall = vs_d & ~vsync_in;
    assign busy    = (state != ST_IDLE);

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        fcnt_nxt      = fcnt;
        latency_nxt   = latency_cyc;
        done_nxt      = 1'b0;
        timeout_nxt   = timeout;
        lt_active_nxt = lt_active;
        lt_mode_nxt   = lt_mode;
`ifdef LAT_TEST_CTRL_AVG_EN
        acc_nxt  = acc;
        run_nxt  = run;
        last_nxt = last;
        acc_sum  = acc + {3'b000, cnt};
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    lt_mode_nxt = mode_sel;
                    timeout_nxt = 1'b0;
                    state_nxt   = ST_ARM;
`ifdef LAT_TEST_CTRL_AVG_EN
                    acc_nxt  = '0;
                    run_nxt  = '0;
                    last_nxt = 1'b0;
`endif
                end
            end
            ST_ARM: begin
                // A sensor already lit at the frame edge would give a bogus
                // zero-latency result, so skip that frame.
                if (vs_fall && !sens_s) begin
                    cnt_nxt       = '0;
                    lt_active_nxt = 1'b1;
                    state_nxt     = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (sens_s) begin
                    lt_active_nxt = 1'b0;
                    fcnt_nxt      = '0;
                    state_nxt     = ST_COOLDOWN;
`ifdef LAT_TEST_CTRL_AVG_EN
                    if (run == AVG_LAST_RUN) begin
                        latency_nxt = acc_sum[CNT_W+2:3];
                        done_nxt    = 1'b1;
                        last_nxt    = 1'b1;
                    end else begin
                        acc_nxt = acc_sum;
                        run_nxt = run + 3'd1;
                    end
`else
                    latency_nxt = cnt;
                    done_nxt    = 1'b1;
`endif
                end else if (cnt == CNT_LAST) begin
                    latency_nxt   = '1;
                    timeout_nxt   = 1'b1;
                    done_nxt      = 1'b1;
                    lt_active_nxt = 1'b0;
                    fcnt_nxt      = '0;
                    state_nxt     = ST_COOLDOWN;
`ifdef LAT_TEST_CTRL_AVG_EN
                    last_nxt = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (fcnt == COOLDOWN_FRAMES && !sens_s) begin
`ifdef LAT_TEST_CTRL_AVG_EN
                    state_nxt = last ? ST_IDLE : ST_ARM;
`else
                    state_nxt = ST_IDLE;
`endif
                end else if (vs_fall && fcnt != COOLDOWN_FRAMES) begin
                    fcnt_nxt = fcnt + 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            fcnt        <= '0;
            latency_cyc <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            lt_active   <= 1'b0;
            lt_mode     <= 2'b00;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            fcnt        <= fcnt_nxt;
            latency_cyc <= latency_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            lt_active   <= lt_active_nxt;
            lt_mode     <= lt_mode_nxt;
        end
    end

`ifdef LAT_TEST_CTRL_AVG_EN
    // Averaging bookkeeping across the 8 back-to-back runs.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            run  <= '0;
            last <= 1'b0;
        end else begin
            acc  <= acc_nxt;
            run  <= run_nxt;
            last <= last_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_lat_test_ctrl.sv
// Bench for lat_test_ctrl: cycle-stamp reference model plus directed scenarios.
module tb_lat_test_ctrl;
    import lat_test_ctrl_pkg::*;

    localparam int CNT_W  = 24;
    localparam int TO_CYC = 28000;
    localparam int CD_FR  = 3;
    localparam int SYNC   = 2;
    localparam int FRAME  = 400;
    localparam int VS_LOW = 8;

    logic             clk27 = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode_sel = 2'b00;
    logic             vsync_in = 1'b1;
    logic             sensor_in = 1'b0;
    logic             lt_active;
    logic [1:0]       lt_mode;
    logic             busy, done, timeout;
    logic [CNT_W-1:0] latency_cyc;

    int checks = 0;
    int failures = 0;
    int falls_total = 0;
    int done_total = 0;
    int cyc = 0;

    lat_test_ctrl #(
        .CNT_W           (CNT_W),
        .TIMEOUT_CYC     (24'(TO_CYC)),
        .COOLDOWN_FRAMES (4'(CD_FR)),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk27       (clk27),
        .reset_n     (reset_n),
        .start       (start),
        .mode_sel    (mode_sel),
        .vsync_in    (vsync_in),
        .sensor_in   (sensor_in),
        .lt_active   (lt_active),
        .lt_mode     (lt_mode),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .latency_cyc (latency_cyc)
    );

    always #5 clk27 = ~clk27;

    task automatic tick();
        @(posedge clk27);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // which: 0 lt_active high, 1 done high, 2 busy low, 3 lt_active low
    task automatic wait_for(input string name, input int which, input int lim, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < lim) begin
            tick();
            n++;
            case (which)
                0:       hit = lt_active;
                1:       hit = done;
                2:       hit = !busy;
                default: hit = !lt_active;
            endcase
        end
        check(name, hit, 1'b1);
    endtask

    // Frame generator: negative VSYNC pulse of VS_LOW cycles every FRAME cycles.
    initial begin
        tick();
        forever begin
            vsync_in = 1'b1;
            repeat (FRAME - VS_LOW) tick();
            vsync_in = 1'b0;
            repeat (VS_LOW) tick();
        end
    end

    // Event counters sampled mid-cycle.
    initial begin
        logic vs_seen;
        vs_seen = 1'b1;
        forever begin
            @(negedge clk27);
            if (vs_seen && !vsync_in) falls_total++;
            vs_seen = vsync_in;
            if (done) done_total++;
        end
    end

    always @(posedge clk27) cyc <= cyc + 1;

    // Reference model: timing expressed with absolute cycle stamps.
    logic [SYNC-1:0]  m_hist = '0;
    logic             m_vs_prev = 1'b0;
    logic             m_busy = 1'b0, m_wait = 1'b0, m_active = 1'b0;
    logic             m_done = 1'b0, m_timeout = 1'b0;
    logic [1:0]       m_mode = 2'b00;
    logic [CNT_W-1:0] m_lat = '0;
    int               m_lit_at = 0;
    int               m_frames = 0;
    logic             m_sens, m_vs_fall;

    assign m_sens    = m_hist[SYNC-1];
    assign m_vs_fall = m_vs_prev & ~vsync_in;

    always @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            m_hist    <= '0;
            m_vs_prev <= 1'b0;
            m_busy    <= 1'b0;
            m_wait    <= 1'b0;
            m_active  <= 1'b0;
            m_done    <= 1'b0;
            m_timeout <= 1'b0;
            m_mode    <= 2'b00;
            m_lat     <= '0;
            m_frames  <= 0;
        end else begin
            m_hist    <= {m_hist[SYNC-2:0], sensor_in};
            m_vs_prev <= vsync_in;
            m_done    <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy    <= 1'b1;
                    m_wait    <= 1'b1;
                    m_mode    <= mode_sel;
                    m_timeout <= 1'b0;
                end
            end else if (m_wait) begin
                if (m_vs_fall && !m_sens) begin
                    m_wait   <= 1'b0;
                    m_active <= 1'b1;
                    m_lit_at <= cyc + 1;
                end
            end else if (m_active) begin
                if (m_sens) begin
                    m_lat    <= CNT_W'(cyc - m_lit_at);
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                    m_frames <= 0;
                end else if (cyc - m_lit_at == TO_CYC - 1) begin
                    m_lat     <= '1;
                    m_timeout <= 1'b1;
                    m_done    <= 1'b1;
                    m_active  <= 1'b0;
                    m_frames  <= 0;
                end
            end else begin
                if (m_frames == CD_FR && !m_sens) m_busy <= 1'b0;
                else if (m_vs_fall && m_frames < CD_FR) m_frames <= m_frames + 1;
            end
        end
    end

`ifndef LAT_TEST_CTRL_AVG_EN
    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk27);
            check("m_lt_active", lt_active, m_active);
            check("m_lt_mode", lt_mode, m_mode);
            check("m_busy", busy, m_busy);
            check("m_done", done, m_done);
            check("m_timeout", timeout, m_timeout);
            check("m_latency", latency_cyc, m_lat);
        end
    end
`endif

    initial begin
        #950000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, f0, d0, sum;
        logic lit_bad;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_lt_active", lt_active, 1'b0);
        check("rst_latency", latency_cyc, 24'd0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_lt_mode", lt_mode, 2'b00);

`ifdef LAT_TEST_CTRL_AVG_EN
        // Eight averaged runs, sensor delays 1000..1007 cycles.
        d0 = done_total;
        sum = 0;
        mode_sel = LT_POS_CENTER;
        pulse_start();
        for (int r = 0; r < 8; r++) begin
            wait_for("t6_active", 0, 2 * FRAME + 10, n);
            repeat (1000 + r) tick();
            sensor_in = 1'b1;
            wait_for("t6_dark", 3, 20, n);
            sensor_in = 1'b0;
            check("t6_busy_held", busy, 1'b1);
            sum += 1000 + r + SYNC;
        end
        wait_for("t6_idle", 2, 6 * FRAME, n);
        check("t6_one_done", done_total - d0, 1);
        check("t6_avg", latency_cyc, 24'd1005);
        check("t6_avg_sum", latency_cyc, sum >> 3);
`else
        // 1: normal measurement, center box.
        mode_sel = LT_POS_CENTER;
        pulse_start();
        check("t1_busy", busy, 1'b1);
        check("t1_mode", lt_mode, LT_POS_CENTER);
        wait_for("t1_active", 0, 2 * FRAME + 10, n);
        repeat (27000 - 1) tick();
        sensor_in = 1'b1;
        wait_for("t1_done", 1, 20, n);
        check("t1_done_delay", n, SYNC + 1);
        check("t1_latency", latency_cyc, 24'd27001);
        check("t1_timeout", timeout, 1'b0);
        sensor_in = 1'b0;
        wait_for("t1_idle", 2, 4 * FRAME + 50, n);

        // 2: sensor never fires.
        mode_sel = LT_POS_TOPLEFT;
        pulse_start();
        wait_for("t2_active", 0, 2 * FRAME + 10, n);
        wait_for("t2_done", 1, TO_CYC + 10, n);
        check("t2_done_delay", n, TO_CYC);
        check("t2_latency", latency_cyc, 24'hFFFFFF);
        check("t2_timeout", timeout, 1'b1);
        wait_for("t2_idle", 2, 4 * FRAME + 50, n);
        check("t2_timeout_sticky", timeout, 1'b1);

        // 3: sensor lit at arm time for two frames.
        sensor_in = 1'b1;
        repeat (5) tick();
        pulse_start();
        check("t2_timeout_cleared", timeout, 1'b0);
        f0 = falls_total;
        n = 0;
        lit_bad = 1'b0;
        while (falls_total < f0 + 2 && n < 3 * FRAME) begin
            tick();
            n++;
            lit_bad |= lt_active;
        end
        repeat (10) begin
            tick();
            lit_bad |= lt_active;
        end
        check("t3_frames_seen", falls_total - f0, 2);
        check("t3_dark_while_lit", lit_bad, 1'b0);
        sensor_in = 1'b0;
        wait_for("t3_active", 0, 2 * FRAME + 10, n);
        repeat (50) tick();
        sensor_in = 1'b1;
        wait_for("t3_done", 1, 20, n);
        check("t3_latency", latency_cyc, 24'd52);
        sensor_in = 1'b0;
        wait_for("t3_idle", 2, 4 * FRAME + 50, n);

        // 4: starts while running are ignored.
        d0 = done_total;
        mode_sel = LT_POS_BOTTOMRIGHT;
        pulse_start();
        wait_for("t4_active", 0, 2 * FRAME + 10, n);
        repeat (20) tick();
        mode_sel = 2'b11;
        pulse_start();
        check("t4_mode_measure", lt_mode, LT_POS_BOTTOMRIGHT);
        repeat (100) tick();
        sensor_in = 1'b1;
        wait_for("t4_done", 1, 20, n);
        f0 = falls_total;
        sensor_in = 1'b0;
        repeat (5) tick();
        mode_sel = LT_POS_TOPLEFT;
        pulse_start();
        check("t4_mode_cooldown", lt_mode, LT_POS_BOTTOMRIGHT);
        check("t4_busy_cooldown", busy, 1'b1);
        wait_for("t4_idle", 2, 4 * FRAME + 50, n);
        check("t4_cool_frames", falls_total - f0, CD_FR);
        check("t4_one_done", done_total - d0, 1);
        repeat (20) tick();
        check("t4_still_idle", busy, 1'b0);

        // 5: asynchronous reset mid-measurement.
        mode_sel = LT_POS_CENTER;
        pulse_start();
        wait_for("t5_active", 0, 2 * FRAME + 10, n);
        repeat (100) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_lt_active", lt_active, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_latency", latency_cyc, 24'd0);
        check("t5_lt_mode", lt_mode, 2'b00);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("t5_idle", busy, 1'b0);
        pulse_start();
        wait_for("t5_active2", 0, 2 * FRAME + 10, n);
        repeat (10) tick();
        sensor_in = 1'b1;
        wait_for("t5_done2", 1, 20, n);
        check("t5_latency2", latency_cyc, 24'd12);
        sensor_in = 1'b0;
        wait_for("t5_idle2", 2, 4 * FRAME + 50, n);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
